// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA pattern generator: pattern encodings and
// colour-bar lookup.
package vga_pattern_gen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_e;

  // Bar colours as {red, green, blue} full-scale flags
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage-0 column/row counters with raw sync, visible and frame-origin decode.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int COL_W    = $clog2(H_TOTAL),
  localparam int ROW_W    = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [COL_W-1:0] column,
  output logic [ROW_W-1:0] row,
  output logic             line_end,
  output logic             origin,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             visible
);

  logic frame_end_s;

  assign line_end    = (column == COL_W'(H_TOTAL - 1));
  assign frame_end_s = line_end && (row == ROW_W'(V_TOTAL - 1));
  assign origin      = (column == '0) && (row == '0);

  // Raster counters: column wraps every line, row wraps at end of frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      column <= '0;
      row    <= '0;
    end else if (enable) begin
      if (line_end) begin
        column <= '0;
        row    <= frame_end_s ? '0 : row + ROW_W'(1);
      end else begin
        column <= column + COL_W'(1);
      end
    end
  end

  assign hsync_act = (column >= COL_W'(H_VISIBLE + H_FRONT)) &&
                     (column <= COL_W'(H_VISIBLE + H_FRONT + H_SYNC - 1));
  assign vsync_act = (row >= ROW_W'(V_VISIBLE + V_FRONT)) &&
                     (row <= ROW_W'(V_VISIBLE + V_FRONT + V_SYNC - 1));
  assign visible   = (column < COL_W'(H_VISIBLE)) && (row < ROW_W'(V_VISIBLE));

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern source with a one-clock registered output stage.
// Build option VGA_PATTERN_GEN_ANIM_EN adds a per-frame horizontal scroll to modes 1 and 3.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int COLOR_BITS       = 4,
  parameter int SYNC_ACTIVE_HIGH = 0,
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int COL_W   = $clog2(H_TOTAL),
  localparam int ROW_W   = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  visible,
  output logic [COL_W-1:0]      column,
  output logic [ROW_W-1:0]      row,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  frame_start
);

  localparam int BAR_W  = H_VISIBLE / 8;
  localparam int BAR_CW = $clog2(BAR_W + 1);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;
  localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};

  logic [COL_W-1:0]      cnt_col_s;
  logic [ROW_W-1:0]      cnt_row_s;
  logic                  line_end_s, origin_s, hsync_act_s, vsync_act_s, visible_s;
  logic [2:0]            bar_idx_r;
  logic [BAR_CW-1:0]     bar_cnt_r;
  logic [2:0]            bar_rgb_s;
  pattern_e              active_mode_r, mode_s;
  logic [COL_W-1:0]      x_s;
  logic [COLOR_BITS-1:0] red_s, green_s, blue_s;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk(clk), .reset(reset), .enable(enable),
    .column(cnt_col_s), .row(cnt_row_s), .line_end(line_end_s), .origin(origin_s),
    .hsync_act(hsync_act_s), .vsync_act(vsync_act_s), .visible(visible_s)
  );

  // Bar index tracks the current stage-0 column without a divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_idx_r <= 3'd0;
      bar_cnt_r <= BAR_CW'(BAR_W - 1);
    end else if (enable) begin
      if (line_end_s) begin
        bar_idx_r <= 3'd0;
        bar_cnt_r <= BAR_CW'(BAR_W - 1);
      end else if (bar_cnt_r == BAR_CW'(0)) begin
        bar_idx_r <= bar_idx_r + 3'd1;
        bar_cnt_r <= BAR_CW'(BAR_W - 1);
      end else begin
        bar_cnt_r <= bar_cnt_r - BAR_CW'(1);
      end
    end
  end

  // The request takes effect on the origin pixel itself, so frames never mix patterns
  assign mode_s = origin_s ? pattern_e'(mode) : active_mode_r;

  // Pattern latch, loaded only at the frame origin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_mode_r <= PAT_BARS;
    end else if (enable && origin_s) begin
      active_mode_r <= pattern_e'(mode);
    end
  end

`ifdef VGA_PATTERN_GEN_ANIM_EN
  logic [7:0] frame_count_r;
  logic [7:0] frame_off_s;

  // Frame counter; the offset stays constant across each whole frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count_r <= 8'd0;
    end else if (enable && origin_s) begin
      frame_count_r <= frame_count_r + 8'd1;
    end
  end

  assign frame_off_s = origin_s ? frame_count_r : frame_count_r - 8'd1;
  assign x_s         = cnt_col_s + COL_W'(frame_off_s);
`else
  assign x_s = cnt_col_s;
`endif

  assign bar_rgb_s = bar_color(bar_idx_r);

  // Pattern colour for the current stage-0 pixel
  always_comb begin
    red_s   = '0;
    green_s = '0;
    blue_s  = '0;
    case (mode_s)
      PAT_BARS: begin
        red_s   = {COLOR_BITS{bar_rgb_s[2]}};
        green_s = {COLOR_BITS{bar_rgb_s[1]}};
        blue_s  = {COLOR_BITS{bar_rgb_s[0]}};
      end
      PAT_CHECK: begin
        if ((1'(x_s >> 3'd5) ^ 1'(cnt_row_s >> 3'd5)) == 1'b1) begin
          red_s = FULL; green_s = FULL; blue_s = FULL;
        end else begin
          red_s = '0; green_s = '0; blue_s = '0;
        end
      end
      PAT_GRAD: begin
        red_s   = COLOR_BITS'(cnt_col_s >> 3'd4);
        green_s = COLOR_BITS'(cnt_row_s >> 3'd4);
        blue_s  = '0;
      end
      PAT_GRID: begin
        if ((5'(x_s) == 5'd0) || (5'(cnt_row_s) == 5'd0)) begin
          red_s = FULL; green_s = FULL; blue_s = FULL;
        end else begin
          red_s = '0; green_s = '0; blue_s = '0;
        end
      end
      default: begin
        red_s = '0; green_s = '0; blue_s = '0;
      end
    endcase
  end

  // Output stage: one clock of latency, all outputs aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      visible     <= 1'b0;
      column      <= '0;
      row         <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hsync       <= hsync_act_s ^ SYNC_IDLE;
      vsync       <= vsync_act_s ^ SYNC_IDLE;
      visible     <= visible_s;
      column      <= cnt_col_s;
      row         <= cnt_row_s;
      red         <= visible_s ? red_s : '0;
      green       <= visible_s ? green_s : '0;
      blue        <= visible_s ? blue_s : '0;
      frame_start <= origin_s;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule
